// File: rtl/ex_issue_ctrl_if.sv
// Handshake and control-word bundle between the ID stage, the EX issue
// controller and the IF/ID hazard logic.
interface ex_issue_ctrl_if;
  logic       instr_valid;
  logic [3:0] opcode;
  logic [2:0] funct_in;
  logic       zero_ex;
  logic       mem_ready;

  logic       WR;
  logic       SOUT;
  logic       WM;
  logic       RM;
  logic       NEQ;
  logic       J;
  logic       JC;
  logic       SIN;
  logic       INA;
  logic [2:0] funct;
  logic       issue_valid;
  logic       stall;
  logic       flush;
  logic       pc_sel;
  logic       mem_err;
  logic       illegal_op;
  logic [7:0] retired;

  // master: the ID stage / environment side
  modport master (
    output instr_valid, opcode, funct_in, zero_ex, mem_ready,
    input  WR, SOUT, WM, RM, NEQ, J, JC, SIN, INA, funct,
    input  issue_valid, stall, flush, pc_sel, mem_err, illegal_op, retired
  );

  // slave: the issue controller itself
  modport slave (
    input  instr_valid, opcode, funct_in, zero_ex, mem_ready,
    output WR, SOUT, WM, RM, NEQ, J, JC, SIN, INA, funct,
    output issue_valid, stall, flush, pc_sel, mem_err, illegal_op, retired
  );
endinterface

// File: rtl/ex_issue_ctrl.sv
// EX-stage issue controller: registers the decoded control word, holds it over
// memory waits, resolves conditional jumps and drives stall/flush/pc_sel.
module ex_issue_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input logic            clock,
  input logic            reset_n,
  ex_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMemWait, StBrResolve, StFlush} state_e;

  typedef struct packed {
    logic       wr;
    logic       sout;
    logic       wm;
    logic       rm;
    logic       neq;
    logic       j;
    logic       jc;
    logic       sin;
    logic       ina;
    logic [2:0] funct;
  } ctrl_t;

  localparam logic [7:0] TmoLast   = 8'(MEM_TIMEOUT - 1);
  localparam logic [2:0] FlushLast = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  ctrl_t      word_q, word_d;
  logic       issue_valid_q, issue_valid_d;
  logic       stall_q, stall_d;
  logic       flush_q, flush_d;
  logic       pc_sel_q, pc_sel_d;
  logic       mem_err_q, mem_err_d;
  logic       illegal_q, illegal_d;
  logic [7:0] retired_q, retired_d;
  logic [7:0] tmo_q, tmo_d;
  logic [2:0] fcnt_q, fcnt_d;

  ctrl_t dec;
  logic  dec_real;
  logic  dec_illegal;
  logic  taken;

  // Opcode decode; undefined opcodes behave as NOP apart from the sticky flag.
  always_comb begin
    dec         = '0;
    dec_real    = 1'b1;
    dec_illegal = 1'b0;
    case (bus.opcode)
      4'h0: dec_real = 1'b0;
      4'h1: begin
        dec.wr    = 1'b1;
        dec.funct = bus.funct_in;
      end
      4'h2: begin
        dec.wr    = 1'b1;
        dec.sin   = 1'b1;
        dec.funct = bus.funct_in;
      end
      4'h3: begin
        dec.rm  = 1'b1;
        dec.wr  = 1'b1;
        dec.sin = 1'b1;
      end
      4'h4: begin
        dec.wm  = 1'b1;
        dec.sin = 1'b1;
      end
      4'h5: dec.j = 1'b1;
      4'h6: dec.jc = 1'b1;
      4'h7: begin
        dec.jc  = 1'b1;
        dec.neq = 1'b1;
      end
      4'h8: dec.sout = 1'b1;
      4'h9: begin
        dec.ina = 1'b1;
        dec.wr  = 1'b1;
      end
      default: begin
        dec_real    = 1'b0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign taken = word_q.neq ? ~bus.zero_ex : bus.zero_ex;

  // stall/flush/pc_sel are registered against the state being entered, so they
  // line up with the cycles the FSM actually spends there.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    issue_valid_d = issue_valid_q;
    stall_d       = 1'b0;
    flush_d       = 1'b0;
    pc_sel_d      = 1'b0;
    mem_err_d     = mem_err_q;
    illegal_d     = illegal_q;
    retired_d     = retired_q;
    tmo_d         = tmo_q;
    fcnt_d        = fcnt_q;

    unique case (state_q)
      StIdle: begin
        word_d        = '0;
        issue_valid_d = 1'b0;
        if (bus.instr_valid) begin
          word_d        = dec;
          issue_valid_d = dec_real;
          if (dec_real) retired_d = retired_q + 8'd1;
          if (dec_illegal) illegal_d = 1'b1;
          if (dec.rm || dec.wm) begin
            state_d = StMemWait;
            stall_d = 1'b1;
            tmo_d   = '0;
          end else if (dec.j) begin
            state_d  = StFlush;
            pc_sel_d = 1'b1;
            flush_d  = 1'b1;
            fcnt_d   = '0;
          end else if (dec.jc) begin
            state_d = StBrResolve;
            stall_d = 1'b1;
          end
        end
      end

      StMemWait: begin
        if (bus.mem_ready) begin
          state_d       = StIdle;
          word_d        = '0;
          issue_valid_d = 1'b0;
        end else if (tmo_q == TmoLast) begin
          state_d       = StIdle;
          word_d        = '0;
          issue_valid_d = 1'b0;
          mem_err_d     = 1'b1;
        end else begin
          stall_d = 1'b1;
          tmo_d   = tmo_q + 8'd1;
        end
      end

      StBrResolve: begin
        word_d        = '0;
        issue_valid_d = 1'b0;
        if (taken) begin
          state_d  = StFlush;
          pc_sel_d = 1'b1;
          flush_d  = 1'b1;
          fcnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end

      StFlush: begin
        word_d        = '0;
        issue_valid_d = 1'b0;
        if (fcnt_q == FlushLast) begin
          state_d = StIdle;
        end else begin
          flush_d = 1'b1;
          fcnt_d  = fcnt_q + 3'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      word_q        <= '0;
      issue_valid_q <= 1'b0;
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      pc_sel_q      <= 1'b0;
      mem_err_q     <= 1'b0;
      illegal_q     <= 1'b0;
      retired_q     <= '0;
      tmo_q         <= '0;
      fcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      issue_valid_q <= issue_valid_d;
      stall_q       <= stall_d;
      flush_q       <= flush_d;
      pc_sel_q      <= pc_sel_d;
      mem_err_q     <= mem_err_d;
      illegal_q     <= illegal_d;
      retired_q     <= retired_d;
      tmo_q         <= tmo_d;
      fcnt_q        <= fcnt_d;
    end
  end

  assign bus.WR          = word_q.wr;
  assign bus.SOUT        = word_q.sout;
  assign bus.WM          = word_q.wm;
  assign bus.RM          = word_q.rm;
  assign bus.NEQ         = word_q.neq;
  assign bus.J           = word_q.j;
  assign bus.JC          = word_q.jc;
  assign bus.SIN         = word_q.sin;
  assign bus.INA         = word_q.ina;
  assign bus.funct       = word_q.funct;
  assign bus.issue_valid = issue_valid_q;
  assign bus.stall       = stall_q;
  assign bus.flush       = flush_q;
  assign bus.pc_sel      = pc_sel_q;
  assign bus.mem_err     = mem_err_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl: stimulus queues hand-computed expected
// output vectors, a monitor pops and compares one per clock edge.
module tb_ex_issue_ctrl;

  logic clock;
  logic reset_n;

  ex_issue_ctrl_if bus ();

  ex_issue_ctrl #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (15)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Control-word bit order: {WR, SOUT, WM, RM, NEQ, J, JC, SIN, INA}
  localparam logic [8:0] W_WR   = 9'h100;
  localparam logic [8:0] W_SOUT = 9'h080;
  localparam logic [8:0] W_WM   = 9'h040;
  localparam logic [8:0] W_RM   = 9'h020;
  localparam logic [8:0] W_NEQ  = 9'h010;
  localparam logic [8:0] W_J    = 9'h008;
  localparam logic [8:0] W_JC   = 9'h004;
  localparam logic [8:0] W_SIN  = 9'h002;
  localparam logic [8:0] W_INA  = 9'h001;

  // {stall, flush, pc_sel}
  localparam logic [2:0] S_NONE  = 3'b000;
  localparam logic [2:0] S_STALL = 3'b100;
  localparam logic [2:0] S_FLUSH = 3'b010;
  localparam logic [2:0] S_PCFL  = 3'b011;

  typedef struct {
    string       tag;
    logic [25:0] v;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_item;
  int   n_checks;
  int   n_fail;
  logic exp_err;
  logic exp_ill;

  function automatic logic [25:0] act_vec();
    return {bus.issue_valid, bus.WR, bus.SOUT, bus.WM, bus.RM, bus.NEQ, bus.J, bus.JC,
            bus.SIN, bus.INA, bus.funct, bus.stall, bus.flush, bus.pc_sel, bus.mem_err,
            bus.illegal_op, bus.retired};
  endfunction

  function automatic logic [25:0] mk(logic iv, logic [8:0] w, logic [2:0] fn, logic [2:0] sfp,
                                     logic err, logic ill, logic [7:0] ret);
    return {iv, w, fn, sfp, err, ill, ret};
  endfunction

  always @(posedge clock) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_item = exp_q.pop_front();
      n_checks++;
      if (act_vec() !== mon_item.v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", mon_item.tag, act_vec(), mon_item.v);
      end
    end
  end

  // One clock of stimulus with the outputs expected right after that edge.
  task automatic step(input string tag, input logic iv, input logic [3:0] op,
                      input logic [2:0] fn, input logic z, input logic mr, input logic e_iv,
                      input logic [8:0] e_w, input logic [2:0] e_fn, input logic [2:0] e_sfp,
                      input logic [7:0] e_ret);
    exp_t e;
    bus.instr_valid = iv;
    bus.opcode      = op;
    bus.funct_in    = fn;
    bus.zero_ex     = z;
    bus.mem_ready   = mr;
    e.tag = tag;
    e.v   = mk(e_iv, e_w, e_fn, e_sfp, exp_err, exp_ill, e_ret);
    exp_q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  task automatic chk_now(input string tag, input logic [25:0] expv);
    n_checks++;
    if (act_vec() !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act_vec(), expv);
    end
  endtask

  task automatic idle(input string tag, input logic [7:0] ret);
    step(tag, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 9'h0, 3'd0, S_NONE, ret);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_err  = 1'b0;
    exp_ill  = 1'b0;
    reset_n  = 1'b0;
    bus.instr_valid = 1'b0;
    bus.opcode      = 4'h0;
    bus.funct_in    = 3'd0;
    bus.zero_ex     = 1'b0;
    bus.mem_ready   = 1'b0;
    #3;
    chk_now("reset_state", 26'h0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    idle("post_reset_idle", 8'd0);

    // ALU issue and the empty cycle after it
    step("alu_issue", 1'b1, 4'h1, 3'b111, 1'b0, 1'b0, 1'b1, W_WR, 3'b111, S_NONE, 8'd1);
    idle("alu_then_idle", 8'd1);

    // LOAD with three wait cycles; funct_in must not leak through
    step("load_issue", 1'b1, 4'h3, 3'b101, 1'b0, 1'b0, 1'b1, W_RM | W_WR | W_SIN, 3'd0,
         S_STALL, 8'd2);
    for (int i = 0; i < 3; i++)
      step("load_wait", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, W_RM | W_WR | W_SIN, 3'd0,
           S_STALL, 8'd2);
    step("load_done", 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 9'h0, 3'd0, S_NONE, 8'd2);

    // STORE whose mem_ready arrives in the 15th wait cycle: success wins
    step("store_late_issue", 1'b1, 4'h4, 3'd0, 1'b0, 1'b0, 1'b1, W_WM | W_SIN, 3'd0,
         S_STALL, 8'd3);
    for (int i = 0; i < 14; i++)
      step("store_late_wait", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, W_WM | W_SIN, 3'd0,
           S_STALL, 8'd3);
    step("store_late_done", 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 9'h0, 3'd0, S_NONE, 8'd3);

    // STORE that times out after 15 wait cycles
    step("store_tmo_issue", 1'b1, 4'h4, 3'd0, 1'b0, 1'b0, 1'b1, W_WM | W_SIN, 3'd0,
         S_STALL, 8'd4);
    for (int i = 0; i < 14; i++)
      step("store_tmo_wait", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, W_WM | W_SIN, 3'd0,
           S_STALL, 8'd4);
    exp_err = 1'b1;
    step("store_timeout", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 9'h0, 3'd0, S_NONE, 8'd4);

    // Normal STORE afterwards; mem_err stays sticky
    step("store2_issue", 1'b1, 4'h4, 3'd0, 1'b0, 1'b0, 1'b1, W_WM | W_SIN, 3'd0,
         S_STALL, 8'd5);
    step("store2_done", 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 9'h0, 3'd0, S_NONE, 8'd5);

    // BEQ taken: one pc_sel pulse, two flush cycles
    step("beq_t_issue", 1'b1, 4'h6, 3'd0, 1'b0, 1'b0, 1'b1, W_JC, 3'd0, S_STALL, 8'd6);
    step("beq_t_resolve", 1'b0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 9'h0, 3'd0, S_PCFL, 8'd6);
    step("beq_t_flush2", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 9'h0, 3'd0, S_FLUSH, 8'd6);
    idle("beq_t_end", 8'd6);

    // BEQ not taken
    step("beq_nt_issue", 1'b1, 4'h6, 3'd0, 1'b0, 1'b0, 1'b1, W_JC, 3'd0, S_STALL, 8'd7);
    step("beq_nt_resolve", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 9'h0, 3'd0, S_NONE, 8'd7);

    // BNE with zero_ex=0 is taken
    step("bne_issue", 1'b1, 4'h7, 3'd0, 1'b0, 1'b0, 1'b1, W_JC | W_NEQ, 3'd0, S_STALL, 8'd8);
    step("bne_resolve", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 9'h0, 3'd0, S_PCFL, 8'd8);
    step("bne_flush2", 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 9'h0, 3'd0, S_FLUSH, 8'd8);
    idle("bne_end", 8'd8);

    // JUMP: pc_sel on the issue edge, instr_valid ignored while flushing
    step("jump_issue", 1'b1, 4'h5, 3'd0, 1'b0, 1'b0, 1'b1, W_J, 3'd0, S_PCFL, 8'd9);
    step("jump_flush_ign", 1'b1, 4'h1, 3'd2, 1'b0, 1'b0, 1'b0, 9'h0, 3'd0, S_FLUSH, 8'd9);
    step("jump_flush_end", 1'b1, 4'h1, 3'd2, 1'b0, 1'b0, 1'b0, 9'h0, 3'd0, S_NONE, 8'd9);

    // Remaining decodes, back to back
    step("alui", 1'b1, 4'h2, 3'b011, 1'b0, 1'b0, 1'b1, W_WR | W_SIN, 3'b011, S_NONE, 8'd10);
    step("out", 1'b1, 4'h8, 3'b110, 1'b0, 1'b0, 1'b1, W_SOUT, 3'd0, S_NONE, 8'd11);
    step("in", 1'b1, 4'h9, 3'b001, 1'b0, 1'b0, 1'b1, W_INA | W_WR, 3'd0, S_NONE, 8'd12);
    step("nop", 1'b1, 4'h0, 3'b111, 1'b0, 1'b0, 1'b0, 9'h0, 3'd0, S_NONE, 8'd12);
    exp_ill = 1'b1;
    step("illegal_c", 1'b1, 4'hC, 3'b111, 1'b0, 1'b0, 1'b0, 9'h0, 3'd0, S_NONE, 8'd12);
    idle("illegal_sticky", 8'd12);

    // Reset dropped during the flush window
    step("jump2_issue", 1'b1, 4'h5, 3'd0, 1'b0, 1'b0, 1'b1, W_J, 3'd0, S_PCFL, 8'd13);
    bus.instr_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_now("reset_mid_flush", 26'h0);
    @(posedge clock);
    #2;
    chk_now("reset_held", 26'h0);
    reset_n = 1'b1;
    exp_err = 1'b0;
    exp_ill = 1'b0;
    idle("after_reset_idle", 8'd0);

    // 256 ALU issues: retired wraps back to 0
    for (int i = 0; i < 256; i++)
      step("wrap_alu", 1'b1, 4'h1, 3'b010, 1'b0, 1'b0, 1'b1, W_WR, 3'b010, S_NONE, 8'(i + 1));
    idle("wrap_end", 8'd0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
